// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port priority arbiter in front of a single-port synchronous RAM.
// Port A wins by default; a starvation counter forces port B through after starve_limit losses.
module mem_arbiter #(
  parameter int addr_width   = 16,
  parameter int data_width   = 8,
  parameter int starve_limit = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [addr_width-1:0] a_addr,
  output logic                  a_ack,
  output logic [data_width-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_ack,
  output logic [data_width-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  ram_cs,
  output logic                  ram_wr,
  output logic                  ram_oe,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_q
);
  localparam int CW = $clog2(starve_limit + 1);
  logic [CW-1:0] r_starve_cnt;
  logic          r_tag1_v, r_tag1_b, r_tag2_v, r_tag2_b;
  logic          w_force_b, w_xfer;
  assign w_force_b = b_req & (r_starve_cnt == CW'(starve_limit));
  assign a_ack     = a_req & ~w_force_b;
  assign b_ack     = b_req & (~a_req | w_force_b);
  assign w_xfer    = a_ack | b_ack;
  assign ram_oe    = ram_cs & ~ram_wr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      ram_cs       <= 1'b0;
      ram_wr       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      r_tag1_v     <= 1'b0;
      r_tag1_b     <= 1'b0;
      r_tag2_v     <= 1'b0;
      r_tag2_b     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
    end else begin
      if (b_ack | ~b_req)
        r_starve_cnt <= '0;
      else if (a_ack && r_starve_cnt != CW'(starve_limit))
        r_starve_cnt <= r_starve_cnt + CW'(1);
      ram_cs   <= w_xfer;
      ram_wr   <= b_ack & b_wr;
      if (w_xfer) ram_addr <= b_ack ? b_addr : a_addr;
      if (b_ack) ram_din <= b_wdata;
      // tag rides alongside the RAM access so the return lands on the right port
      r_tag1_v <= w_xfer & ~(b_ack & b_wr);
      r_tag1_b <= b_ack;
      r_tag2_v <= r_tag1_v;
      r_tag2_b <= r_tag1_b;
      a_rvalid <= r_tag2_v & ~r_tag2_b;
      b_rvalid <= r_tag2_v & r_tag2_b;
      if (r_tag2_v & ~r_tag2_b) a_rdata <= ram_q;
      if (r_tag2_v & r_tag2_b) b_rdata <= ram_q;
    end
  end
endmodule
